regfile_hilo: RTL

Architectural state sink at the far end of the writeback path. Consumes the WB-to-RF bus and commits GPR writes into a 32x32 register file and HI/LO writes into the HI and LO registers. Serves two combinational GPR read ports and the HI/LO read port to the ID/EX stages. Same-cycle writes are bypassed write-first to the read ports, so decode never sees stale WB data.

---
 rtl/regfile_hilo_if.sv | 48 ++++
 rtl/regfile_hilo.sv | 139 +++++++++++++
 2 files changed

// File: rtl/regfile_hilo_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_hilo_if
//  Description : WB-to-RF bus plus the GPR and HI/LO read ports of the
//                architectural register file. The master side (writeback and
//                ID/EX) drives the bus and read addresses; the slave side
//                (register file) returns read data.
//  Revision    : 1.0  initial release
// ============================================================================
interface regfile_hilo_if #(
  parameter int DATA_W  = 32,
  parameter int REG_NUM = 32
);

  localparam int ADDR_W = $clog2(REG_NUM);
  // {hi_we, lo_we, hi_wdata, lo_wdata, rf_we, rf_waddr, rf_wdata}
  localparam int BUS_W  = 3 * DATA_W + ADDR_W + 3;

  logic [BUS_W-1:0]  wb_to_rf_bus;
  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic [DATA_W-1:0] hi_rdata;
  logic [DATA_W-1:0] lo_rdata;

  modport master (
    output wb_to_rf_bus,
    output raddr1,
    output raddr2,
    input  rdata1,
    input  rdata2,
    input  hi_rdata,
    input  lo_rdata
  );

  modport slave (
    input  wb_to_rf_bus,
    input  raddr1,
    input  raddr2,
    output rdata1,
    output rdata2,
    output hi_rdata,
    output lo_rdata
  );

endinterface
`default_nettype wire

// File: rtl/regfile_hilo.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_hilo
//  Description : 32x32 GPR file plus HI/LO registers at the end of the
//                writeback path. Two combinational GPR read ports and a HI/LO
//                read port, with optional write-first bypass of the write
//                presented in the same cycle. $0 is hard-wired to zero.
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_hilo #(
  parameter int DATA_W    = 32,
  parameter int REG_NUM   = 32,
  parameter int BYPASS_EN = 1
) (
  input  wire logic     clk,
  input  wire logic     rst,
  regfile_hilo_if.slave rf
);

  localparam int ADDR_W = $clog2(REG_NUM);

  // Bit positions inside the WB-to-RF bus word (LSB first).
  localparam int RF_WADDR_LSB = DATA_W;
  localparam int RF_WE_BIT    = DATA_W + ADDR_W;
  localparam int LO_WDATA_LSB = RF_WE_BIT + 1;
  localparam int HI_WDATA_LSB = LO_WDATA_LSB + DATA_W;
  localparam int LO_WE_BIT    = HI_WDATA_LSB + DATA_W;
  localparam int HI_WE_BIT    = LO_WE_BIT + 1;

  // --------------------------------------------------------------------------
  // Bus field extraction
  // --------------------------------------------------------------------------
  logic              hi_we;
  logic              lo_we;
  logic [DATA_W-1:0] hi_wdata;
  logic [DATA_W-1:0] lo_wdata;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  assign hi_we    = rf.wb_to_rf_bus[HI_WE_BIT];
  assign lo_we    = rf.wb_to_rf_bus[LO_WE_BIT];
  assign hi_wdata = rf.wb_to_rf_bus[HI_WDATA_LSB +: DATA_W];
  assign lo_wdata = rf.wb_to_rf_bus[LO_WDATA_LSB +: DATA_W];
  assign rf_we    = rf.wb_to_rf_bus[RF_WE_BIT];
  assign rf_waddr = rf.wb_to_rf_bus[RF_WADDR_LSB +: ADDR_W];
  assign rf_wdata = rf.wb_to_rf_bus[DATA_W-1:0];

  // A GPR write only counts when it targets a non-zero register; this keeps
  // $0 untouched and stops the bypass from ever sourcing a $0 write.
  logic gpr_wr;
  assign gpr_wr = rf_we && (rf_waddr != '0);

  // --------------------------------------------------------------------------
  // Architectural state
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] regs [REG_NUM];
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  // Commit GPR writes; reset clears the whole array and discards any write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs[i] <= '0;
      end
    end else if (gpr_wr) begin
      regs[rf_waddr] <= rf_wdata;
    end
  end

  // Commit HI and LO independently; both may update on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (hi_we) hi_q <= hi_wdata;
      if (lo_we) lo_q <= lo_wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Bypass selects
  // --------------------------------------------------------------------------
  logic byp1;
  logic byp2;
  logic byp_hi;
  logic byp_lo;

  generate
    if (BYPASS_EN != 0) begin : g_bypass
      assign byp1   = gpr_wr && (rf.raddr1 == rf_waddr);
      assign byp2   = gpr_wr && (rf.raddr2 == rf_waddr);
      assign byp_hi = hi_we;
      assign byp_lo = lo_we;
    end else begin : g_no_bypass
      assign byp1   = 1'b0;
      assign byp2   = 1'b0;
      assign byp_hi = 1'b0;
      assign byp_lo = 1'b0;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Read ports
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic [DATA_W-1:0] hi_rd;
  logic [DATA_W-1:0] lo_rd;

  // GPR reads: zero during reset or for $0, else bypassed write or stored value.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (!rst) begin
      if (rf.raddr1 != '0) rd1 = byp1 ? rf_wdata : regs[rf.raddr1];
      if (rf.raddr2 != '0) rd2 = byp2 ? rf_wdata : regs[rf.raddr2];
    end
  end

  // HI/LO reads: zero during reset, else bypassed write or stored value.
  always_comb begin
    hi_rd = '0;
    lo_rd = '0;
    if (!rst) begin
      hi_rd = byp_hi ? hi_wdata : hi_q;
      lo_rd = byp_lo ? lo_wdata : lo_q;
    end
  end

  assign rf.rdata1   = rd1;
  assign rf.rdata2   = rd2;
  assign rf.hi_rdata = hi_rd;
  assign rf.lo_rdata = lo_rd;

endmodule
`default_nettype wire
